// File: rtl/audio_pkg.sv
// audio_pkg: channel tags, default sample widths and pairing FSM encoding shared by the audio blocks
package audio_pkg;
   localparam logic CH_LEFT    = 1'b0;
   localparam logic CH_RIGHT   = 1'b1;
   localparam int   DATA_WIDTH = 32;
   localparam int   OUT_WIDTH  = 24;
   typedef enum logic {WAIT_L = 1'b0, HAVE_L = 1'b1} pair_state_e;
endpackage

// File: rtl/audio_sync_fifo.sv
// audio_sync_fifo: first-word-fall-through FIFO with registered flags
// The head entry sits in an output register that is counted as one of the DEPTH entries.
module audio_sync_fifo #(
   parameter int WIDTH = 24,
   parameter int DEPTH = 512
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_wr_en,
   input  logic [WIDTH-1:0] i_wr_data,
   input  logic             i_rd_en,
   output logic [WIDTH-1:0] o_rd_data,
   output logic             o_full,
   output logic             o_empty
);
   localparam int AW = $clog2(DEPTH);
   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wp, r_rp;
   logic [AW:0]      r_cnt;
   logic [WIDTH-1:0] r_out;
   logic             r_out_vld, r_full;
   logic             w_wr, w_pop, w_mem_nz, w_load, w_bypass, w_mem_wr;
   logic [AW:0]      w_cnt_nxt;
   assign w_wr      = i_wr_en && !r_full;
   assign w_pop     = i_rd_en && r_out_vld;
   assign w_mem_nz  = r_cnt > (AW+1)'(r_out_vld);
   assign w_load    = (!r_out_vld || w_pop) && w_mem_nz;
   // a write into a one-entry FIFO that is being drained goes straight to the head: no bubble
   assign w_bypass  = w_pop && !w_mem_nz && w_wr;
   assign w_mem_wr  = w_wr && !w_bypass;
   assign w_cnt_nxt = r_cnt + (AW+1)'(w_wr) - (AW+1)'(w_pop);
   assign o_rd_data = r_out;
   assign o_full    = r_full;
   assign o_empty   = !r_out_vld;
   always_ff @(posedge clk)
      if (w_mem_wr) r_mem[r_wp] <= i_wr_data;
   always_ff @(posedge clk) begin
      if (rst) begin
         r_wp      <= '0;
         r_rp      <= '0;
         r_cnt     <= '0;
         r_out     <= '0;
         r_out_vld <= 1'b0;
         r_full    <= 1'b0;
      end else begin
         r_wp      <= r_wp + AW'(w_mem_wr);
         r_rp      <= r_rp + AW'(w_load);
         r_cnt     <= w_cnt_nxt;
         r_full    <= w_cnt_nxt == (AW+1)'(DEPTH);
         r_out_vld <= w_load || w_bypass || (r_out_vld && !w_pop);
         if (w_load || w_bypass) r_out <= w_load ? r_mem[r_rp] : i_wr_data;
      end
   end
endmodule

// File: rtl/audio_frame_packer.sv
// audio_frame_packer: downmixes interleaved L/R samples to mono, buffers them and
// emits FRAME_LEN-sample AXI-Stream frames; input is never stalled, losses are flagged.
module audio_frame_packer #(
   parameter int DATA_WIDTH = audio_pkg::DATA_WIDTH,
   parameter int OUT_WIDTH  = audio_pkg::OUT_WIDTH,
   parameter int FRAME_LEN  = 256,
   parameter int FIFO_DEPTH = 512
) (
   input  logic                  AXIS_ACLK,
   input  logic                  AXIS_ARESET,
   input  logic                  S_AXIS_TVALID,
   output logic                  S_AXIS_TREADY,
   input  logic [DATA_WIDTH-1:0] S_AXIS_TDATA,
   input  logic                  S_AXIS_TLAST,
   output logic                  M_AXIS_TVALID,
   input  logic                  M_AXIS_TREADY,
   output logic [OUT_WIDTH-1:0]  M_AXIS_TDATA,
   output logic                  M_AXIS_TLAST,
   input  logic                  status_clear,
   output logic                  overflow,
   output logic [7:0]            sync_err_count
);
   import audio_pkg::*;
   localparam int CW = $clog2(FRAME_LEN);
   pair_state_e           r_state, w_state_nxt;
   logic [DATA_WIDTH-1:0] r_left;
   logic [OUT_WIDTH-1:0]  r_mono, w_mono;
   logic                  r_mono_vld;
   logic [CW-1:0]         r_pos;
   logic                  w_is_right, w_form, w_store_l, w_err, w_full, w_empty, w_hs;
   assign S_AXIS_TREADY = !AXIS_ARESET;
   assign w_is_right    = S_AXIS_TLAST == CH_RIGHT;
   // (L + R) >>> 1 on DATA_WIDTH+1 bits, keeping only the top OUT_WIDTH bits of the mean
   assign w_mono = OUT_WIDTH'(({r_left[DATA_WIDTH-1], r_left} + {S_AXIS_TDATA[DATA_WIDTH-1], S_AXIS_TDATA})
                              >> (DATA_WIDTH + 1 - OUT_WIDTH));
   always_ff @(posedge AXIS_ACLK)
      r_state <= AXIS_ARESET ? WAIT_L : w_state_nxt;
   always_comb begin
      w_state_nxt = S_AXIS_TVALID ? (w_is_right ? WAIT_L : HAVE_L) : r_state;
      w_store_l   = S_AXIS_TVALID && S_AXIS_TLAST == CH_LEFT;
      w_form      = S_AXIS_TVALID && w_is_right && r_state == HAVE_L;
      w_err       = S_AXIS_TVALID && ((r_state == WAIT_L) == w_is_right);
   end
   always_ff @(posedge AXIS_ACLK) begin
      if (AXIS_ARESET) begin
         r_left         <= '0;
         r_mono         <= '0;
         r_mono_vld     <= 1'b0;
         r_pos          <= '0;
         overflow       <= 1'b0;
         sync_err_count <= '0;
      end else begin
         if (w_store_l) r_left <= S_AXIS_TDATA;
         if (w_form) r_mono <= w_mono;
         r_mono_vld <= w_form;
         if (w_hs) r_pos <= (r_pos == CW'(FRAME_LEN - 1)) ? '0 : r_pos + CW'(1);
         if (status_clear) begin
            overflow       <= 1'b0;
            sync_err_count <= '0;
         end else begin
            if (r_mono_vld && w_full) overflow <= 1'b1;
            if (w_err && sync_err_count != 8'hFF) sync_err_count <= sync_err_count + 8'd1;
         end
      end
   end
   audio_sync_fifo #(.WIDTH(OUT_WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk       (AXIS_ACLK),
      .rst       (AXIS_ARESET),
      .i_wr_en   (r_mono_vld),
      .i_wr_data (r_mono),
      .i_rd_en   (M_AXIS_TREADY),
      .o_rd_data (M_AXIS_TDATA),
      .o_full    (w_full),
      .o_empty   (w_empty)
   );
   assign M_AXIS_TVALID = !w_empty;
   assign w_hs          = M_AXIS_TVALID && M_AXIS_TREADY;
   assign M_AXIS_TLAST  = M_AXIS_TVALID && r_pos == CW'(FRAME_LEN - 1);
endmodule

// File: doc/audio_frame_packer.md
# audio_frame_packer

Downstream neighbour of the I2S receiver: consumes its AXI-Stream of interleaved stereo samples and downmixes each left/right pair to one mono sample. Mono samples are buffered in a FIFO and re-emitted as fixed-length frames (TLAST on the last sample of each frame) for the FFT/visualizer stage. Input backpressure is never applied, because the receiver does not honour TREADY; loss on a full FIFO is flagged, not stalled.

## Interface
- DATA_WIDTH, 32: input sample width, signed, MSB-aligned audio.
- OUT_WIDTH, 24: output sample width; the top OUT_WIDTH bits of the mono sum are kept (truncation). Must be ≤ DATA_WIDTH.
- FRAME_LEN, 256: mono samples per output frame, ≥2.
- FIFO_DEPTH, 512: mono FIFO entries, power of two, ≥ FRAME_LEN.
- AXIS_ACLK  in  1  single clock for all logic.
- AXIS_ARESET  in  1  reset, synchronous, active-high.
- S_AXIS_TVALID  in  1  input sample valid.
- S_AXIS_TREADY  out  1  0 while AXIS_ARESET is high, 1 otherwise.
- S_AXIS_TDATA  in  DATA_WIDTH  signed sample.
- S_AXIS_TLAST  in  1  channel tag: 0 = left, 1 = right (closes the stereo pair).
- M_AXIS_TVALID  out  1  mono sample valid.
- M_AXIS_TREADY  in  1  downstream ready.
- M_AXIS_TDATA  out  OUT_WIDTH  signed mono sample.
- M_AXIS_TLAST  out  1  high on sample FRAME_LEN-1 of each frame.
- status_clear  in  1  single-cycle pulse; clears overflow and sync_err_count.
- overflow  out  1  sticky: at least one mono sample dropped on a full FIFO.
- sync_err_count  out  8  saturating count of channel-order violations.

## Operation
- Pairing FSM: states WAIT_L, HAVE_L. Reset goes to WAIT_L.
  - WAIT_L, left accepted: store it, go to HAVE_L.
  - WAIT_L, right accepted: discard it, sync_err_count +1, stay in WAIT_L.
  - HAVE_L, right accepted: form mono, go to WAIT_L.
  - HAVE_L, left accepted: replace the stored left, sync_err_count +1, stay in HAVE_L.
- Mono arithmetic: sum = L + R, sign-extended to DATA_WIDTH+1 bits. mono = sum >>> 1, arithmetic, giving DATA_WIDTH bits; it cannot overflow. Output is mono[DATA_WIDTH-1 -: OUT_WIDTH].
- FIFO write: mono is written one cycle after the right sample is accepted.
  - Fullness is evaluated before any same-cycle read. If the FIFO is full, the sample is dropped and overflow is set, even if a read occurs in that cycle.
- Frame position counter, 0..FRAME_LEN-1:
  - Advances only on output handshakes (M_AXIS_TVALID && M_AXIS_TREADY) and wraps to 0 after FRAME_LEN-1.
  - M_AXIS_TLAST = (counter == FRAME_LEN-1) while TVALID is high.
  - Dropped samples do not advance it, so frames always contain FRAME_LEN delivered samples.
- Output AXIS rules:
  - M_AXIS_TVALID never depends combinationally on M_AXIS_TREADY.
  - TDATA and TLAST are held stable while TVALID && !TREADY.
  - Output is back-to-back capable: one sample per cycle while the FIFO is non-empty and TREADY is high.
- sync_err_count saturates at 255.
- status_clear:
  - Takes priority over a same-cycle set or increment.
  - Does not touch the FIFO, the FSM or the frame counter.

## Timing
- Reset values:
  - Outputs: M_AXIS_TVALID = 0, M_AXIS_TDATA = 0, M_AXIS_TLAST = 0, overflow = 0, sync_err_count = 0.
  - Internal: FIFO empty, FSM in WAIT_L, frame counter 0.
- Reset in mid-operation: the stored left sample, FIFO contents and frame position are all discarded. The next cycle behaves as after power-up reset.
- Latency, FIFO empty and M_AXIS_TREADY high:
  - Right sample accepted at clock edge k.
  - FIFO write at edge k+1.
  - M_AXIS_TVALID high after edge k+2.
- FIFO status:
  - Full means FIFO_DEPTH entries.
  - A FIFO holding exactly one entry that is read and written in the same cycle keeps TVALID high with no bubble.
- S_AXIS_TVALID with no handshake partner is ignored only during reset; otherwise every TVALID cycle is a transfer.

## Structure
- Shared package audio_pkg holds:
  - channel encoding constants CH_LEFT = 0 and CH_RIGHT = 1, used by this block and the I2S receiver;
  - default widths DATA_WIDTH = 32 and OUT_WIDTH = 24;
  - the FSM state encoding.
- One sub-module, audio_sync_fifo: parameters WIDTH and DEPTH, synchronous active-high reset, registered full/empty flags, first-word-fall-through read.
- Pairing, arithmetic and framing logic live in the top module.

## Test plan
- Pair L = 0x00010000, R = 0x00030000 with TREADY = 1 -> M_AXIS_TDATA = 0x000200, TVALID rises 2 edges after R.
- Pairs (0x80000000, 0x80000000) and (0x00001000, 0xFFFFF000) -> 0x800000, then 0x000000; no overflow of the sum.
- 3*FRAME_LEN valid pairs with random TREADY (50%) -> exactly 768 outputs, TLAST on outputs 255, 511 and 767, data in order, TDATA stable while stalled.
- Sequence R, L, L, R -> sync_err_count = 2, one output equal to the mean of the second L and the final R; status_clear -> count 0.
- TREADY held 0 for FIFO_DEPTH+3 pairs -> overflow = 1; after release, exactly 512 samples emerge (the first 512 mono values).
- Reset asserted while in HAVE_L with 10 samples queued -> TVALID 0 next cycle; a following lone R increments sync_err_count and yields no output.
